decode_issue_stage: RTL and testbench

//  ID stage front end, directly upstream of the register file and feeding execute.
//  - Accepts IF/ID instruction; drives register-file read addresses.
//  - Forwards in-flight EX/MEM results; stalls one cycle on load-use.
//  - Holds the result in the ID/EX pipeline register behind a valid/ready handshake.

---
 rtl/decode_pkg.sv | 46 ++++
 rtl/decode_issue_stage_if.sv | 32 +++
 rtl/operand_forward_mux.sv | 28 ++
 rtl/decode_issue_stage.sv | 131 +++++++++++++
 tb/tb_decode_issue_stage.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared widths, RV32 opcode constants and instruction field helpers
// for the decode/issue stage.
//   No ports. Exports XLEN/ILEN/REG_DEPTH/REG_AW, the opcode localparams and
//   the opcode/rs1/rs2/rd slice and source-use helpers.
package decode_pkg;
    localparam int XLEN      = 32;
    localparam int ILEN      = 32;
    localparam int REG_DEPTH = 32;
    localparam int REG_AW    = $clog2(REG_DEPTH);

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    function automatic logic [6:0] opcode_of(input logic [ILEN-1:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [ILEN-1:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [ILEN-1:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic [4:0] rd_of(input logic [ILEN-1:0] instr);
        return instr[11:7];
    endfunction

    // U-type and JAL carry immediate bits in the rs1 field, so it must not
    // create false load-use stalls for them.
    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == LUI || op == AUIPC || op == JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op == OP || op == STORE || op == BRANCH;
    endfunction
endpackage

// File: rtl/decode_issue_stage_if.sv
// decode_issue_stage_if: IF/ID input handshake and ID/EX output handshake.
//   in_valid/in_ready/in_instr/in_pc      : instruction arriving from fetch
//   out_valid/out_ready/out_*             : registered payload toward execute
//   master modport = environment (fetch + execute), slave modport = the stage.
interface decode_issue_stage_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    import decode_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [ILEN-1:0] in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [ILEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [AW-1:0]   out_rd_address;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_rs1_val, out_rs2_val, out_rd_address
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_rs1_val, out_rs2_val, out_rd_address
    );
endinterface

// File: rtl/operand_forward_mux.sv
// operand_forward_mux: priority select of one source operand.
//   addr            : source register index
//   rf_data         : register file read data
//   ex_* / mem_*    : in-flight results from execute and memory stages
//   value           : x0 -> 0, else EX (non-load) -> MEM -> register file
module operand_forward_mux #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic [AW-1:0]   ex_addr,
    input  logic            ex_write_en,
    input  logic            ex_is_load,
    input  logic [XLEN-1:0] ex_data,
    input  logic [AW-1:0]   mem_addr,
    input  logic            mem_write_en,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] value
);
    logic ex_hit;
    logic mem_hit;

    // A load in execute has no data yet; the stage stalls instead of forwarding it.
    assign ex_hit  = addr == ex_addr && ex_write_en && !ex_is_load;
    assign mem_hit = addr == mem_addr && mem_write_en;
    assign value   = addr == '0 ? '0 : ex_hit ? ex_data : mem_hit ? mem_data : rf_data;
endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: ID front end with operand forwarding, load-use stall and
// the ID/EX pipeline register.
//   clk, rst_n              : clock, synchronous active-low reset
//   bus (slave)             : IF/ID input and ID/EX output handshakes
//   rs1/rs2_address/_data   : register file read port (combinational data)
//   ex_* / mem_*            : results in flight in execute and memory
//   flush                   : redirect, kills the ID/EX register contents
//   stall_count             : saturating count of load-use stall cycles
module decode_issue_stage #(
    parameter int XLEN      = 32,
    parameter int REG_DEPTH = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    decode_issue_stage_if.slave          bus,
    output logic [$clog2(REG_DEPTH)-1:0] rs1_address,
    output logic [$clog2(REG_DEPTH)-1:0] rs2_address,
    input  logic [XLEN-1:0]              rs1_data,
    input  logic [XLEN-1:0]              rs2_data,
    input  logic [$clog2(REG_DEPTH)-1:0] ex_rd_address,
    input  logic                         ex_rd_write_en,
    input  logic                         ex_is_load,
    input  logic [XLEN-1:0]              ex_rd_data,
    input  logic [$clog2(REG_DEPTH)-1:0] mem_rd_address,
    input  logic                         mem_rd_write_en,
    input  logic [XLEN-1:0]              mem_rd_data,
    input  logic                         flush,
    output logic [CNT_WIDTH-1:0]         stall_count
);
    import decode_pkg::*;

    localparam int AW = $clog2(REG_DEPTH);

    logic [6:0]      opcode;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            hazard;
    logic            can_advance;
    logic            ready;
    logic            accept;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    logic                 valid_q;
    logic [ILEN-1:0]      instr_q;
    logic [XLEN-1:0]      pc_q;
    logic [XLEN-1:0]      rs1_q;
    logic [XLEN-1:0]      rs2_q;
    logic [AW-1:0]        rd_q;
    logic [CNT_WIDTH-1:0] stall_q;

    assign opcode      = opcode_of(bus.in_instr);
    assign rs1         = AW'(rs1_of(bus.in_instr));
    assign rs2         = AW'(rs2_of(bus.in_instr));
    assign rs1_address = rs1;
    assign rs2_address = rs2;

    assign hazard = bus.in_valid && ex_is_load && ex_rd_write_en && ex_rd_address != '0 &&
                    ((uses_rs1(opcode) && rs1 == ex_rd_address) ||
                     (uses_rs2(opcode) && rs2 == ex_rd_address));

    // The ID/EX register can take a new entry when empty or being drained.
    assign can_advance  = !valid_q || bus.out_ready;
    assign ready        = rst_n && !flush && !hazard && can_advance;
    assign accept       = bus.in_valid && ready;
    assign bus.in_ready = ready;

    operand_forward_mux #(.XLEN(XLEN), .AW(AW)) u_fwd_rs1 (
        .addr         (rs1),
        .rf_data      (rs1_data),
        .ex_addr      (ex_rd_address),
        .ex_write_en  (ex_rd_write_en),
        .ex_is_load   (ex_is_load),
        .ex_data      (ex_rd_data),
        .mem_addr     (mem_rd_address),
        .mem_write_en (mem_rd_write_en),
        .mem_data     (mem_rd_data),
        .value        (rs1_val)
    );

    operand_forward_mux #(.XLEN(XLEN), .AW(AW)) u_fwd_rs2 (
        .addr         (rs2),
        .rf_data      (rs2_data),
        .ex_addr      (ex_rd_address),
        .ex_write_en  (ex_rd_write_en),
        .ex_is_load   (ex_is_load),
        .ex_data      (ex_rd_data),
        .mem_addr     (mem_rd_address),
        .mem_write_en (mem_rd_write_en),
        .mem_data     (mem_rd_data),
        .value        (rs2_val)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            stall_q <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
                instr_q <= bus.in_instr;
                pc_q    <= bus.in_pc;
                rs1_q   <= rs1_val;
                rs2_q   <= rs2_val;
                rd_q    <= AW'(rd_of(bus.in_instr));
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
            // Backpressure cycles are not load-use stalls and are not counted.
            if (hazard && !flush && can_advance && !(&stall_q)) begin
                stall_q <= stall_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_instr      = instr_q;
    assign bus.out_pc         = pc_q;
    assign bus.out_rs1_val    = rs1_q;
    assign bus.out_rs2_val    = rs2_q;
    assign bus.out_rd_address = rd_q;
    assign stall_count        = stall_q;
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: scoreboard bench for decode_issue_stage. Expected
// ID/EX payloads are queued when an instruction is accepted and compared on
// the following cycle; handshake, hold, flush and stall-count behaviour are
// checked directly. The stall counter is built 3 bits wide so saturation is reachable.
module tb_decode_issue_stage;
    localparam int CW = 3;

    localparam logic [31:0] ADD312 = {7'd0, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
    localparam logic [31:0] ADD612 = {7'd0, 5'd2, 5'd1, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADD400 = {7'd0, 5'd0, 5'd0, 3'd0, 5'd4, 7'b0110011};
    localparam logic [31:0] SW21   = {7'd0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011};
    localparam logic [31:0] LUI5   = {7'd0, 5'd0, 5'd5, 3'd0, 5'd5, 7'b0110111};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs1_address;
    logic [4:0]    rs2_address;
    logic [31:0]   rs1_data;
    logic [31:0]   rs2_data;
    logic [4:0]    ex_rd_address;
    logic          ex_rd_write_en;
    logic          ex_is_load;
    logic [31:0]   ex_rd_data;
    logic [4:0]    mem_rd_address;
    logic          mem_rd_write_en;
    logic [31:0]   mem_rd_data;
    logic          flush;
    logic [CW-1:0] stall_count;

    int   checks = 0;
    int   failures = 0;
    exp_t cur_exp;
    exp_t exp_q[$];

    decode_issue_stage_if #(.XLEN(32), .AW(5)) bus ();

    decode_issue_stage #(.XLEN(32), .REG_DEPTH(32), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .rs1_address     (rs1_address),
        .rs2_address     (rs2_address),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .ex_rd_address   (ex_rd_address),
        .ex_rd_write_en  (ex_rd_write_en),
        .ex_is_load      (ex_is_load),
        .ex_rd_data      (ex_rd_data),
        .mem_rd_address  (mem_rd_address),
        .mem_rd_write_en (mem_rd_write_en),
        .mem_rd_data     (mem_rd_data),
        .flush           (flush),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_pc    = pc;
        cur_exp      = '{instr, pc, rs1, rs2, instr[11:7]};
    endtask

    // One clock: note acceptance mid-cycle, then score the captured payload.
    task automatic tick();
        logic acc;
        exp_t e;
        @(negedge clk);
        acc = rst_n && bus.in_valid && bus.in_ready;
        if (acc) exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
        if (acc) begin
            e = exp_q.pop_front();
            check("sb_valid", bus.out_valid, 1);
            check("sb_instr", bus.out_instr, e.instr);
            check("sb_pc",    bus.out_pc, e.pc);
            check("sb_rs1",   bus.out_rs1_val, e.rs1);
            check("sb_rs2",   bus.out_rs2_val, e.rs2);
            check("sb_rd",    bus.out_rd_address, e.rd);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        rs1_data = 32'd5;
        rs2_data = 32'd7;
        ex_rd_address = '0;
        ex_rd_write_en = 1'b0;
        ex_is_load = 1'b0;
        ex_rd_data = '0;
        mem_rd_address = '0;
        mem_rd_write_en = 1'b0;
        mem_rd_data = '0;
        flush = 1'b0;
        send(ADD312, 32'h100, 32'd5, 32'd7);

        // Reset with a valid instruction waiting
        tick();
        tick();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_stall", stall_count, 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_rs1", bus.out_rs1_val, 0);
        check("rst_out_rd", bus.out_rd_address, 0);

        // Plain ADD x3,x1,x2 from the register file
        rst_n = 1'b1;
        #1;
        check("rs1_address", rs1_address, 1);
        check("rs2_address", rs2_address, 2);
        check("add_in_ready", bus.in_ready, 1);
        tick();

        // EX and MEM both hit x1: EX wins
        ex_rd_address = 5'd1; ex_rd_write_en = 1'b1; ex_rd_data = 32'hAA;
        mem_rd_address = 5'd1; mem_rd_write_en = 1'b1; mem_rd_data = 32'hBB;
        send(ADD312, 32'h104, 32'hAA, 32'd7);
        #1 check("fwd_in_ready", bus.in_ready, 1);
        tick();
        // EX not writing: MEM supplies x1
        ex_rd_write_en = 1'b0;
        send(ADD312, 32'h108, 32'hBB, 32'd7);
        tick();
        // MEM hit on rs2 only
        mem_rd_address = 5'd2;
        send(ADD312, 32'h10C, 32'd5, 32'hBB);
        tick();
        mem_rd_write_en = 1'b0;

        // Load-use on rs2 of a store: one bubble, then forward from EX
        ex_is_load = 1'b1; ex_rd_address = 5'd2; ex_rd_write_en = 1'b1; ex_rd_data = 32'h33;
        send(SW21, 32'h110, 32'd5, 32'h33);
        #1 check("lu_in_ready", bus.in_ready, 0);
        tick();
        check("lu_bubble", bus.out_valid, 0);
        check("lu_stall", stall_count, 1);
        ex_is_load = 1'b0;
        #1 check("lu_release_ready", bus.in_ready, 1);
        tick();
        check("lu_stall_after", stall_count, 1);

        // Backpressure with a hazard present: payload held, nothing counted
        bus.out_ready = 1'b0;
        ex_is_load = 1'b1; ex_rd_address = 5'd1;
        send(ADD612, 32'h114, 32'd5, 32'd7);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", bus.in_ready, 0);
            tick();
            check("bp_valid", bus.out_valid, 1);
            check("bp_instr", bus.out_instr, SW21);
            check("bp_pc", bus.out_pc, 32'h110);
            check("bp_rs2", bus.out_rs2_val, 32'h33);
            check("bp_stall", stall_count, 1);
        end
        flush = 1'b1;
        tick();
        check("flush_valid", bus.out_valid, 0);
        check("flush_stall", stall_count, 1);
        tick();
        check("flush_hazard_stall", stall_count, 1);
        ex_is_load = 1'b0;
        #1 check("flush_in_ready", bus.in_ready, 0);
        tick();
        check("flush_valid2", bus.out_valid, 0);

        // LUI ignores rs1 for hazards; x0 reads zero regardless of MEM x0 write
        flush = 1'b0; bus.out_ready = 1'b1;
        ex_is_load = 1'b1; ex_rd_address = 5'd5; ex_rd_write_en = 1'b1;
        mem_rd_address = 5'd0; mem_rd_write_en = 1'b1; mem_rd_data = 32'hFF;
        rs1_data = 32'h11; rs2_data = 32'h22;
        send(LUI5, 32'h200, 32'h11, 32'd0);
        #1 check("lui_in_ready", bus.in_ready, 1);
        tick();
        ex_rd_address = 5'd0;
        send(ADD400, 32'h204, 32'd0, 32'd0);
        #1 check("x0_in_ready", bus.in_ready, 1);
        tick();
        check("x0_stall", stall_count, 1);
        mem_rd_write_en = 1'b0;

        // Long load-use stall drives the counter into saturation
        ex_rd_address = 5'd1;
        send(ADD312, 32'h208, 32'h11, 32'h22);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("sat_stall", stall_count, (i + 2 > 7) ? 7 : i + 2);
        end
        check("sat_valid", bus.out_valid, 0);

        // Capture once more, then reset overrides a simultaneous flush
        ex_is_load = 1'b0;
        send(ADD312, 32'h300, 32'h33, 32'h22);
        tick();
        rst_n = 1'b0;
        flush = 1'b1;
        #1 check("rst2_in_ready", bus.in_ready, 0);
        tick();
        check("rst2_valid", bus.out_valid, 0);
        check("rst2_instr", bus.out_instr, 0);
        check("rst2_rs1", bus.out_rs1_val, 0);
        check("rst2_stall", stall_count, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
